// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MEM/WB bundle field positions, write-back
// select encodings and the write-back stage FSM state encoding.
package pipe_pkg;

  localparam int unsigned MEMWB_W    = 105;
  localparam int unsigned RD_LO      = 0;
  localparam int unsigned RD_HI      = 4;
  localparam int unsigned LDATA_LO   = 5;
  localparam int unsigned LDATA_HI   = 36;
  localparam int unsigned ALU_LO     = 37;
  localparam int unsigned ALU_HI     = 68;
  localparam int unsigned WBSEL_LO   = 69;
  localparam int unsigned WBSEL_HI   = 70;
  localparam int unsigned REGW_BIT   = 71;
  localparam int unsigned SQUASH_BIT = 72;
  localparam int unsigned PC_LO      = 73;
  localparam int unsigned PC_HI      = 104;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_NONE = 2'b11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_mux.sv
// Write-back value selection: ALU result, load data or link address (PC+4).
module wb_mux
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] ldata,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      wb_sel,
  output logic [XLEN-1:0] wdata
);

  // Select the value written back; WB_NONE yields zero (never written).
  always_comb begin
    wdata = '0;
    unique case (wb_sel)
      WB_ALU:  wdata = alu;
      WB_MEM:  wdata = ldata;
      WB_LINK: wdata = pc + XLEN'(4);
      default: wdata = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM/WB bundle, drives the register-file
// write port and forwarding tap, counts retired instructions and handles
// the squash flag. Optional macro WB_TRACE_EN adds a per-retire trace line
// and an internal cycle counter.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SQUASH_HOLD = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [MEMWB_W-1:0] memwb,
  input  logic               memwb_valid,
  input  logic               stall,
  output logic               memwb_ready,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               fwd_valid,
  output logic [4:0]         fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic [CNT_W-1:0]   retire_count,
  output logic [XLEN-1:0]    last_pc,
  output logic               squashing
);

  wb_state_e       state, state_n;
  logic [2:0]      hold_cnt, hold_cnt_n;
  logic            accept, run_eff, drop, we_n, retire;
  logic [4:0]      rd;
  logic [1:0]      wb_sel;
  logic            is_squash;
  logic [XLEN-1:0] pc, wdata;

  assign rd        = memwb[RD_HI:RD_LO];
  assign wb_sel    = memwb[WBSEL_HI:WBSEL_LO];
  assign is_squash = memwb[SQUASH_BIT];
  assign pc        = memwb[PC_LO +: XLEN];

  wb_mux #(.XLEN(XLEN)) u_mux (
    .alu    (memwb[ALU_LO +: XLEN]),
    .ldata  (memwb[LDATA_LO +: XLEN]),
    .pc     (pc),
    .wb_sel (wb_sel),
    .wdata  (wdata)
  );

  assign memwb_ready = !stall;
  assign fwd_valid   = rf_we;
  assign fwd_rd      = rf_waddr;
  assign fwd_data    = rf_wdata;
  assign squashing   = (state == ST_SQUASH);

  // Next-state, hold counter and accept/drop/write decisions.
  // SQUASH with the counter at 0 behaves as RUN for the bundle accepted
  // that cycle, so the exit cycle already writes and retires.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    accept     = memwb_valid && !stall;
    run_eff    = (state == ST_RUN) || (hold_cnt == '0);
    drop       = !run_eff || is_squash;
    retire     = accept && !drop;
    we_n       = retire && memwb[REGW_BIT] && (wb_sel != WB_NONE) && (rd != '0);
    if (state == ST_SQUASH) begin
      if (hold_cnt != '0) hold_cnt_n = hold_cnt - 3'd1;
      else                state_n    = ST_RUN;
    end
    if (accept && is_squash && (SQUASH_HOLD != 0)) begin
      state_n    = ST_SQUASH;
      hold_cnt_n = 3'(SQUASH_HOLD);
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_RUN;
      hold_cnt     <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      retire_count <= '0;
      last_pc      <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      rf_we    <= we_n;
      if (accept) begin
        rf_waddr <= rd;
        rf_wdata <= wdata;
      end
      if (retire) begin
        retire_count <= retire_count + CNT_W'(1);
        last_pc      <= pc;
      end
    end
  end

`ifdef WB_TRACE_EN
  logic [63:0] cycle;

  // Free-running cycle counter for trace timestamps.
  always_ff @(posedge CLK) begin
    if (RESET) cycle <= '0;
    else       cycle <= cycle + 64'd1;
  end

  // One trace line per retired instruction.
  always_ff @(posedge CLK) begin
    if (!RESET && retire)
      $display("WB cyc=%0d pc=%h rd=%0d data=%h we=%0b", cycle, pc, rd, wdata, we_n);
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a stimulus process pushes expected
// post-edge state from a timestamp-based reference model; a monitor pops
// and compares one entry per clock edge.
module tb_wb_stage;

  localparam int unsigned H = 2;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [104:0] memwb = '0;
  logic         memwb_valid = 1'b0;
  logic         stall = 1'b0;
  logic         memwb_ready, rf_we, fwd_valid, squashing;
  logic [4:0]   rf_waddr, fwd_rd;
  logic [31:0]  rf_wdata, fwd_data, retire_count, last_pc;

  always #5 CLK = ~CLK;

  wb_stage #(.XLEN(32), .SQUASH_HOLD(H), .CNT_W(32)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .memwb        (memwb),
    .memwb_valid  (memwb_valid),
    .stall        (stall),
    .memwb_ready  (memwb_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .retire_count (retire_count),
    .last_pc      (last_pc),
    .squashing    (squashing)
  );

  typedef struct {
    logic        ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rc;
    logic [31:0] lpc;
    logic        sq;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_no = 0;

  // Reference model: absolute edge numbers, not FSM states.
  // last_sq_edge = edge at which the latest squash bundle was accepted;
  // bundles accepted at edges up to last_sq_edge+H are dropped and
  // squashing is high after those same edges.
  longint      last_sq_edge = -1000;
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rc = '0;
  logic [31:0] m_lpc = '0;

  function automatic logic [31:0] wb_value(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] ld, input logic [31:0] pc);
    case (sel)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h exp=%h", name, edge_no, got, exp);
    end
  endtask

  // One clock of stimulus; the model computes what the DUT must show after
  // the coming rising edge and queues it.
  task automatic step(input logic rst, input logic v, input logic st,
                      input logic [4:0] rd, input logic [31:0] ld, input logic [31:0] alu,
                      input logic [1:0] sel, input logic rw, input logic sq,
                      input logic [31:0] pc);
    exp_t x;
    logic drop;
    @(negedge CLK);
    RESET = rst; memwb_valid = v; stall = st;
    memwb = {pc, sq, rw, sel, alu, ld, rd};
    edge_no++;
    if (rst) begin
      m_we = 0; m_waddr = '0; m_wdata = '0; m_rc = '0; m_lpc = '0;
      last_sq_edge = -1000;
    end else if (v && !st) begin
      drop = sq || (longint'(edge_no) <= last_sq_edge + longint'(H));
      if (sq && H > 0) last_sq_edge = edge_no;
      m_waddr = rd;
      m_wdata = wb_value(sel, alu, ld, pc);
      m_we = !drop && rw && (sel != 2'd3) && (rd != 5'd0);
      if (!drop) begin
        m_rc = m_rc + 32'd1;
        m_lpc = pc;
      end
    end else begin
      m_we = 0;
    end
    x.ready = !st;
    x.we = m_we; x.waddr = m_waddr; x.wdata = m_wdata;
    x.rc = m_rc; x.lpc = m_lpc;
    x.sq = (longint'(edge_no) <= last_sq_edge + longint'(H));
    q.push_back(x);
  endtask

  task automatic idle(input logic st);
    step(0, 0, st, '0, '0, '0, 2'd0, 0, 0, '0);
  endtask

  // Monitor: every edge that has a queued expectation is compared.
  initial begin
    exp_t x;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("memwb_ready", 32'(memwb_ready), 32'(x.ready));
        chk("rf_we", 32'(rf_we), 32'(x.we));
        chk("rf_waddr", 32'(rf_waddr), 32'(x.waddr));
        chk("rf_wdata", rf_wdata, x.wdata);
        chk("fwd_valid", 32'(fwd_valid), 32'(x.we));
        chk("fwd_rd", 32'(fwd_rd), 32'(x.waddr));
        chk("fwd_data", fwd_data, x.wdata);
        chk("retire_count", retire_count, x.rc);
        chk("last_pc", last_pc, x.lpc);
        chk("squashing", 32'(squashing), 32'(x.sq));
      end
    end
  end

  initial begin
    int unsigned wait_cnt;
    // reset
    step(1, 1, 0, 5'd3, 32'h1, 32'h2, 2'd0, 1, 0, 32'h100);
    step(1, 0, 1, '0, '0, '0, 2'd0, 0, 0, '0);
    // ALU write
    step(0, 1, 0, 5'd5, 32'h5555, 32'h1234, 2'd0, 1, 0, 32'h1000);
    // link with PC wrap
    step(0, 1, 0, 5'd31, 32'h0, 32'h9, 2'd2, 1, 0, 32'hFFFFFFFC);
    // x0 suppressed load, then real load
    step(0, 1, 0, 5'd0, 32'hCAFEF00D, 32'h0, 2'd1, 1, 0, 32'h1004);
    step(0, 1, 0, 5'd7, 32'hDEADBEEF, 32'h0, 2'd1, 1, 0, 32'h1008);
    // stall three cycles, then release
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 5'd9, 32'h0, 32'h99, 2'd0, 1, 0, 32'h100C);
    step(0, 1, 0, 5'd9, 32'h0, 32'h99, 2'd0, 1, 0, 32'h100C);
    idle(0);
    // WB_NONE with reg_write set
    step(0, 1, 0, 5'd4, 32'h1, 32'h2, 2'd3, 1, 0, 32'h1010);
    // squash followed by three back-to-back writes
    step(0, 1, 0, 5'd1, 32'h0, 32'h11, 2'd0, 1, 1, 32'h2000);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 5'(10 + i), 32'h0, 32'(32'h20 + i), 2'd0, 1, 0, 32'(32'h2004 + 4 * i));
    idle(0);
    // stalled squash bundle is not accepted
    step(0, 1, 1, 5'd1, 32'h0, 32'h11, 2'd0, 1, 1, 32'h3000);
    idle(0);
    // reset in the middle of SQUASH, then a normal write
    step(0, 1, 0, 5'd2, 32'h0, 32'h22, 2'd0, 1, 1, 32'h4000);
    step(0, 1, 0, 5'd3, 32'h0, 32'h33, 2'd0, 1, 0, 32'h4004);
    step(1, 0, 0, '0, '0, '0, 2'd0, 0, 0, '0);
    step(0, 1, 0, 5'd6, 32'h0, 32'h66, 2'd0, 1, 0, 32'h4008);
    // squash while already squashing reloads the hold
    step(0, 1, 0, 5'd2, 32'h0, 32'h1, 2'd0, 1, 1, 32'h5000);
    step(0, 1, 1, 5'd2, 32'h0, 32'h2, 2'd0, 1, 0, 32'h5004);
    step(0, 1, 0, 5'd2, 32'h0, 32'h3, 2'd0, 1, 1, 32'h5008);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 5'd8, 32'h0, 32'(i), 2'd0, 1, 0, 32'h500C);
    // randomized traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 20), 5'($urandom_range(0, 31)), $urandom(), $urandom(),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 8), $urandom());
    idle(0);
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge CLK);
      wait_cnt++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the five-stage CPU pipeline; the consuming end of the 105-bit MEM/WB bundle that the memory stage produces.
- Registers the bundle, selects the write-back value and drives the register-file write port.
- Also provides a forwarding tap for EX, a retired-instruction counter and squash handling for the pipeline-reset flag carried in the bundle.

Parameters:
- XLEN, 32, datapath and PC width.
- SQUASH_HOLD, 2, cycles write-back stays suppressed after a squash-flagged bundle is accepted (range 0..7).
- CNT_W, 32, width of the retire counter.

Ports:
- CLK  in  1  pipeline clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- memwb  in  105  MEM/WB bundle: [4:0] rd; [36:5] load data; [68:37] ALU result; [70:69] wb_sel; [71] reg_write; [72] squash; [104:73] instruction PC.
- memwb_valid  in  1  bundle present this cycle.
- stall  in  1  hazard-unit hold; the bundle is not accepted while high.
- memwb_ready  out  1  stage accepts this cycle; equals !stall.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- fwd_valid  out  1  forwarding tap valid; mirrors rf_we.
- fwd_rd  out  5  forwarding tap destination; mirrors rf_waddr.
- fwd_data  out  XLEN  forwarding tap value; mirrors rf_wdata.
- retire_count  out  CNT_W  count of retired instructions.
- last_pc  out  XLEN  PC of the most recently retired instruction.
- squashing  out  1  high while in state SQUASH.

Behaviour:
- Reset (RESET=1 at a rising edge): every output register goes to 0 (rf_we, rf_waddr, rf_wdata, retire_count, last_pc); state goes to RUN. RESET overrides stall and valid.
- Accept condition: memwb_valid && !stall. Accepted bundles are registered; outputs update at the next edge, giving 1-cycle latency from accept to rf_we.
- Write-back value by wb_sel:
  - 00: ALU result.
  - 01: load data.
  - 10: PC+4, computed modulo 2^XLEN (link).
  - 11: no write; rf_we is forced to 0.
- rf_we = reg_write && wb_sel!=11 && rd!=0 && state==RUN at accept. A write to x0 is always suppressed, but the instruction still retires.
- Retire: an accepted, non-squash bundle in RUN increments retire_count by 1 (wrapping at 2^CNT_W) and loads last_pc.
- Cycle with no accept (stall or !valid): rf_we=0 on the next cycle; rf_waddr, rf_wdata and last_pc hold.
- FSM (2 states):
  - RUN → SQUASH when an accepted bundle has squash=1. That bundle causes no write and no retire; the hold counter loads SQUASH_HOLD.
  - SQUASH: every accepted bundle is dropped (no write, no retire). The counter decrements each cycle, stalled or not. Exit to RUN the cycle the counter is at 0.
  - SQUASH_HOLD=0: the state stays RUN; only the squash-flagged bundle itself is dropped.
  - A squash bundle accepted while already in SQUASH reloads the counter with SQUASH_HOLD.
- Simultaneous events: stall=1 with a squash bundle present means the bundle is not accepted and no state change occurs. RESET during SQUASH returns to RUN with the counter at 0.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: each retire prints one simulation trace line with cycle number, PC, rd, data and the we flag. Also adds an internal cycle counter cleared by RESET.
- Undefined: no trace statements and no cycle counter; port list and timing are identical.

Decomposition:
- Shared package pipe_pkg holds:
  - MEMWB field bit-position constants (RD_LO/HI, LDATA_LO/HI, ALU_LO/HI, WBSEL_LO/HI, REGW_BIT, SQUASH_BIT, PC_LO/HI);
  - wb_sel encodings WB_ALU=2'b00, WB_MEM=2'b01, WB_LINK=2'b10, WB_NONE=2'b11;
  - the FSM state encoding.
  The EX/MEM builders reuse the same constants.
- One natural sub-module, wb_mux: combinational selection of the write-back value from the bundle fields, wb_sel and PC+4.

Test Plan:
- ALU write: bundle rd=5, alu=0x1234, wb_sel=00, reg_write=1, valid=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, fwd_* identical; retire_count=1.
- Link wrap: wb_sel=10, pc=0xFFFFFFFC, rd=31 → rf_wdata=0x00000000; last_pc=0xFFFFFFFC.
- x0 suppression plus load: rd=0, wb_sel=01, reg_write=1 → rf_we=0 and retire_count increments. Then rd=7, ldata=0xDEADBEEF → rf_wdata=0xDEADBEEF.
- Stall: valid=1, stall=1 for 3 cycles → memwb_ready=0, rf_we=0, rf_wdata held, retire_count unchanged. Release → write occurs 1 cycle later.
- Squash with SQUASH_HOLD=2: squash bundle, then 3 valid writes back-to-back → squashing=1 for 3 cycles and the first two writes are dropped. The third write reaches rf_we=1, and retire_count increases by exactly 1.
- Reset mid-SQUASH: assert RESET for 1 cycle → squashing=0, retire_count=0, rf_we=0. The next valid bundle writes normally.
